// File: rtl/maze_pkg.sv
// Shared definitions for the maze cell RAM: cell codes, maze geometry,
// requester IDs and the arbiter FSM state encoding.
package maze_pkg;

    localparam int MAZE_ROWS = 64;
    localparam int MAZE_COLS = 64;
    localparam int ADDR_W    = 12;

    typedef enum logic [1:0] {
        WALL     = 2'b00,
        FRONTIER = 2'b01,
        CARVED   = 2'b10,
        PATH     = 2'b11
    } cell_t;

    localparam logic [1:0] ID_DISP = 2'd0;
    localparam logic [1:0] ID_CARV = 2'd1;
    localparam logic [1:0] ID_PLYR = 2'd2;

    typedef enum logic {
        ST_SERVE = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/maze_rr_arb.sv
// Two-way round-robin arbiter. Side a is the carver, side b the player.
// The pointer remembers who was served last so the other side wins a tie.
module maze_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic en,
    output logic gnt_a,
    output logic gnt_b
);

    logic prefer_b;

    // Grant decision: tie goes to the side not served most recently
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && (!req_b || !prefer_b)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    // Pointer only moves when one of the two sides is actually granted
    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_b <= 1'b0;
        end else if (gnt_a) begin
            prefer_b <= 1'b1;
        end else if (gnt_b) begin
            prefer_b <= 1'b0;
        end
    end

endmodule

// File: rtl/maze_ram_arbiter.sv
// Single-port maze cell RAM arbiter: display (read-only, highest priority),
// carver and player-logic share the RAM; a clear sweep wipes every cell to WALL.
module maze_ram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    input  logic              carv_req,
    input  logic              carv_we,
    input  logic [ADDR_W-1:0] carv_addr,
    input  logic [DATA_W-1:0] carv_wdata,
    output logic              carv_gnt,
    input  logic              plyr_req,
    input  logic              plyr_we,
    input  logic [ADDR_W-1:0] plyr_addr,
    input  logic [DATA_W-1:0] plyr_wdata,
    output logic              plyr_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        rd_id,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done
);
    import maze_pkg::*;

    localparam int CNT_W = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX - 1);

    arb_state_t        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [CNT_W-1:0]  starve_carv;
    logic [CNT_W-1:0]  starve_plyr;
    logic              vld_p1;
    logic [1:0]        id_p1;

    logic serve;
    logic clearing;
    logic carv_urgent;
    logic plyr_urgent;
    logic urgent_any;
    logic disp_win;
    logic rr_en;
    logic rr_req_a;
    logic rr_req_b;
    logic rr_gnt_a;
    logic rr_gnt_b;

    // Starve counter step: hold during the sweep, clear when served or idle,
    // otherwise count up and stick at the override threshold
    function automatic logic [CNT_W-1:0] next_starve(
        input logic             req,
        input logic             gnt,
        input logic             hold,
        input logic [CNT_W-1:0] cnt
    );
        if (hold) begin
            return cnt;
        end
        if (!req || gnt) begin
            return '0;
        end
        if (cnt == STARVE_TOP) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    // Arbitration: a starved low-priority requester beats display; the
    // round-robin resolves carver vs player among urgent or ordinary requests
    always_comb begin
        serve       = (state == ST_SERVE) && !reset;
        clearing    = (state == ST_CLEAR) && !reset;
        carv_urgent = carv_req && (starve_carv == STARVE_TOP);
        plyr_urgent = plyr_req && (starve_plyr == STARVE_TOP);
        urgent_any  = carv_urgent || plyr_urgent;
        disp_win    = serve && disp_req && !urgent_any;
        rr_en       = serve && !disp_win;
        rr_req_a    = urgent_any ? carv_urgent : carv_req;
        rr_req_b    = urgent_any ? plyr_urgent : plyr_req;
    end

    maze_rr_arb u_rr (
        .clk   (clk),
        .reset (reset),
        .req_a (rr_req_a),
        .req_b (rr_req_b),
        .en    (rr_en),
        .gnt_a (rr_gnt_a),
        .gnt_b (rr_gnt_b)
    );

    // RAM command mux: sweep write, or the granted requester's access
    always_comb begin
        disp_gnt  = disp_win;
        carv_gnt  = rr_gnt_a;
        plyr_gnt  = rr_gnt_b;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (clearing) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = DATA_W'(WALL);
        end else if (disp_win) begin
            ram_en    = 1'b1;
            ram_addr  = disp_addr;
        end else if (rr_gnt_a) begin
            ram_en    = 1'b1;
            ram_we    = carv_we;
            ram_addr  = carv_addr;
            ram_wdata = carv_wdata;
        end else if (rr_gnt_b) begin
            ram_en    = 1'b1;
            ram_we    = plyr_we;
            ram_addr  = plyr_addr;
            ram_wdata = plyr_wdata;
        end
    end

    // Control FSM: SERVE <-> CLEAR with registered busy/done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SERVE;
            clr_addr   <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_SERVE: begin
                    if (clear_start) begin
                        state      <= ST_CLEAR;
                        clr_addr   <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == '1) begin
                        state      <= ST_SERVE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: state <= ST_SERVE;
            endcase
        end
    end

    // Starve counters for the two low-priority requesters
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_carv <= '0;
            starve_plyr <= '0;
        end else begin
            starve_carv <= next_starve(carv_req, carv_gnt, state == ST_CLEAR, starve_carv);
            starve_plyr <= next_starve(plyr_req, plyr_gnt, state == ST_CLEAR, starve_plyr);
        end
    end

    // Stage p0 -> p1: remember a granted read and who issued it
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            id_p1  <= ID_DISP;
        end else begin
            vld_p1 <= serve && ram_en && !ram_we;
            if (serve && ram_en && !ram_we) begin
                id_p1 <= disp_win ? ID_DISP : (rr_gnt_a ? ID_CARV : ID_PLYR);
            end
        end
    end

    // Read return is the RAM output tagged with the stored requester ID
    always_comb begin
        rd_valid = vld_p1 && !reset;
        rd_id    = id_p1;
        rd_data  = rd_valid ? ram_rdata : '0;
    end

endmodule
